// File: rtl/uart_tx.sv
// UART transmitter: pops words from the TX FIFO over valid/ready and sends start, data (LSB first), optional parity, stop.
// Optional parity bit is enabled by defining UART_TX_PARITY_EN (adds parameter PARITY_ODD).
module uart_tx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  txd_o,
    output logic                  busy_o
);

    // Handshake: a word moves on a posedge where tx_valid_i && tx_ready_o; ready is only offered in IDLE.
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W       = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = $clog2(DATA_WIDTH + 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
        end
        if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
            $error("uart_tx: DATA_WIDTH must be in 5..9");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  txd_q, txd_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  bit_end;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    assign bit_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = bit_end ? '0 : baud_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                baud_d  = '0;
                bit_d   = '0;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                if (tx_valid_i && ready_q) begin
                    state_d  = S_START;
                    shift_d  = tx_data_i;
                    txd_d    = 1'b0;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^tx_data_i) ^ PARITY_ODD;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                    shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                // bit_q is the index of the data bit currently on the line
                if (bit_end) begin
                    if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = parity_q;
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        txd_d   = shift_q[0];
                        shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                    bit_d   = '0;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    assign txd_o      = txd_q;
    assign tx_ready_o = ready_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at CLKS_PER_BIT=8: every cycle of every frame is compared with a per-bit frame model.
module tb_uart_tx;

    localparam int CPB = 8;
    localparam int DW  = 8;
    localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PB  = 1;
    localparam bit ODD = 1'b0;
`else
    localparam int PB  = 0;
`endif
    localparam int NBITS     = 1 + DW + PB + SB;
    localparam int FRAME_CYC = NBITS * CPB;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          tx_valid_i = 1'b0;
    logic [DW-1:0] tx_data_i = '0;
    logic          tx_ready_o;
    logic          txd_o;
    logic          busy_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int hs_cyc, prev_hs;
    logic [0:0] exp_q[$];
    logic [DW-1:0] cur_d, pend_d;
    logic pend_en, prev_pend;
    int pend_at;

    uart_tx #(
        .CLK_FREQ  (8),
        .BAUD_RATE (1),
        .DATA_WIDTH(DW),
        .STOP_BITS (SB)
`ifdef UART_TX_PARITY_EN
        ,
        .PARITY_ODD(ODD)
`endif
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .tx_valid_i(tx_valid_i),
        .tx_ready_o(tx_ready_o),
        .tx_data_i (tx_data_i),
        .txd_o     (txd_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer d and wait for ready; returns just after the handshake edge.
    task automatic handshake(input logic [DW-1:0] d, output int at_cyc);
        int waited;
        waited = 0;
        tx_valid_i = 1'b1;
        tx_data_i  = d;
        while (tx_ready_o !== 1'b1 && waited < 2 * FRAME_CYC) begin
            step();
            waited++;
        end
        check("hs_timeout", 32'(waited < 2 * FRAME_CYC), 1);
        step();
        at_cyc = cyc;
    endtask

    // Expected line levels of one frame, one entry per bit slot.
    task automatic build_frame(input logic [DW-1:0] d);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        exp_q.push_back((^d) ^ ODD);
`endif
        for (int i = 0; i < SB; i++) exp_q.push_back(1'b1);
    endtask

    // Called just after the handshake edge; optionally raises valid with the next word at cycle p_at.
    task automatic frame_check(input logic [DW-1:0] d, input logic p_en, input int p_at,
                               input logic [DW-1:0] p_d);
        build_frame(d);
        for (int c = 0; c <= FRAME_CYC; c++) begin
            if (p_en && c == p_at) begin
                tx_valid_i = 1'b1;
                tx_data_i  = p_d;
            end else if (!(p_en && c > p_at)) begin
                tx_valid_i = 1'b0;
                tx_data_i  = DW'($urandom);
            end
            check($sformatf("txd d=%0h c=%0d", d, c), txd_o,
                  (c < FRAME_CYC) ? exp_q[c / CPB] : 1'b1);
            check($sformatf("busy d=%0h c=%0d", d, c), busy_o, (c < FRAME_CYC) ? 1 : 0);
            check($sformatf("ready d=%0h c=%0d", d, c), tx_ready_o, (c < FRAME_CYC) ? 0 : 1);
            if (c < FRAME_CYC) step();
        end
    endtask

    initial begin
        // reset held for three edges, then released
        #1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_txd", txd_o, 1);
            check("rst_busy", busy_o, 0);
            check("rst_ready", tx_ready_o, 0);
        end
        rst_i = 1'b0;
        step();
        check("rel_ready", tx_ready_o, 1);
        check("rel_txd", txd_o, 1);

        // single 0x55
        handshake(8'h55, hs_cyc);
        frame_check(8'h55, 1'b0, 0, '0);

        // back-to-back 0xA3 then 0x0F with valid held high
        handshake(8'hA3, prev_hs);
        frame_check(8'hA3, 1'b1, 0, 8'h0F);
        handshake(8'h0F, hs_cyc);
        check("b2b_gap", hs_cyc - prev_hs, FRAME_CYC + 1);
        frame_check(8'h0F, 1'b0, 0, '0);

        // backpressure: 0xFF offered mid-frame
        handshake(8'h3C, prev_hs);
        frame_check(8'h3C, 1'b1, 37, 8'hFF);
        handshake(8'hFF, hs_cyc);
        check("bp_gap", hs_cyc - prev_hs, FRAME_CYC + 1);
        frame_check(8'hFF, 1'b0, 0, '0);

        // parity-sensitive words
        handshake(8'h07, hs_cyc);
        frame_check(8'h07, 1'b0, 0, '0);
        handshake(8'h03, hs_cyc);
        frame_check(8'h03, 1'b0, 0, '0);

        // randomized words, random idle gaps and random mid-frame offers
        prev_pend = 1'b0;
        prev_hs   = 0;
        cur_d     = DW'($urandom);
        for (int i = 0; i < 10; i++) begin
            handshake(cur_d, hs_cyc);
            if (prev_pend) check($sformatf("rnd_gap %0d", i), hs_cyc - prev_hs, FRAME_CYC + 1);
            pend_en = 1'($urandom_range(0, 1));
            pend_at = $urandom_range(0, FRAME_CYC);
            pend_d  = DW'($urandom);
            frame_check(cur_d, pend_en, pend_at, pend_d);
            prev_pend = pend_en;
            prev_hs   = hs_cyc;
            if (pend_en) begin
                cur_d = pend_d;
            end else begin
                cur_d = DW'($urandom);
                repeat ($urandom_range(0, 5)) step();
            end
        end

        // reset at cycle 30 of a 0x00 frame
        handshake(8'h00, hs_cyc);
        tx_valid_i = 1'b0;
        for (int c = 0; c < 30; c++) begin
            check($sformatf("pre_rst_txd c=%0d", c), txd_o, 0);
            if (c == 29) rst_i = 1'b1;
            step();
        end
        for (int i = 0; i < 2; i++) begin
            check("midrst_txd", txd_o, 1);
            check("midrst_busy", busy_o, 0);
            check("midrst_ready", tx_ready_o, 0);
            if (i == 1) rst_i = 1'b0;
            step();
        end
        check("post_rst_ready", tx_ready_o, 1);
        for (int i = 0; i < 20; i++) begin
            check("post_rst_txd", txd_o, 1);
            check("post_rst_busy", busy_o, 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
